// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if -- request/grant/status bundle between sequencing FSMs
// (master) and the shared tick scheduler (slave).
//   REQ     [NCH]     per-requester load request, held until GNT
//   REQ_VAL [NCH*CW]  load value, slice [i*CW +: CW] belongs to requester i
//   CANCEL  [NCH]     abort channel i without DONE
//   RELOAD  [NCH]     periodic-mode select (only with TICK_SCHED_AUTORELOAD_EN)
//   GNT     [NCH]     one-hot, 1-cycle grant pulse
//   BUSY    [NCH]     channel i counting
//   DONE    [NCH]     1-cycle expiry pulse
//   TICK              1-cycle time-base pulse
interface tick_scheduler_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 16
);
  logic [NCH-1:0]    REQ;
  logic [NCH*CW-1:0] REQ_VAL;
  logic [NCH-1:0]    CANCEL;
`ifdef TICK_SCHED_AUTORELOAD_EN
  logic [NCH-1:0]    RELOAD;
`endif
  logic [NCH-1:0]    GNT;
  logic [NCH-1:0]    BUSY;
  logic [NCH-1:0]    DONE;
  logic              TICK;

`ifdef TICK_SCHED_AUTORELOAD_EN
  modport master (output REQ, REQ_VAL, CANCEL, RELOAD,
                  input  GNT, BUSY, DONE, TICK);
  modport slave  (input  REQ, REQ_VAL, CANCEL, RELOAD,
                  output GNT, BUSY, DONE, TICK);
`else
  modport master (output REQ, REQ_VAL, CANCEL,
                  input  GNT, BUSY, DONE, TICK);
  modport slave  (input  REQ, REQ_VAL, CANCEL,
                  output GNT, BUSY, DONE, TICK);
`endif
endinterface

// File: rtl/tick_scheduler.sv
// tick_scheduler -- shared millisecond time base plus NCH countdown channels.
// Requesters load a delay (in ticks) through a round-robin arbitrated port;
// the channel pulses DONE on the V-th TICK after the load.
// Ports:
//   CLK    system clock, all logic on posedge
//   RST_N  synchronous reset, active-low
//   bus    tick_scheduler_if.slave (REQ/REQ_VAL/CANCEL[/RELOAD] in,
//          GNT/BUSY/DONE/TICK out)
// Optional feature: define TICK_SCHED_AUTORELOAD_EN to add per-load RELOAD
// (periodic channels that reload V at expiry and stay BUSY).
module tick_scheduler #(
  parameter int unsigned CLK_DIV = 12000,
  parameter int unsigned NCH     = 4,
  parameter int unsigned CW      = 16
) (
  input logic             CLK,
  input logic             RST_N,
  tick_scheduler_if.slave bus
);

  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // Time base
  logic [DW-1:0]  psc_q, psc_d;
  logic           tick_q, tick_d;

  // Arbiter
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic [NCH-1:0] elig;
  logic           win_vld;
  logic [PW-1:0]  win_idx;

  // Channels
  ch_state_e      st_q  [NCH];
  ch_state_e      st_d  [NCH];
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [NCH-1:0] done_q, done_d;
  logic [NCH-1:0] busy;
`ifdef TICK_SCHED_AUTORELOAD_EN
  logic [NCH-1:0] per_q, per_d;
  logic [CW-1:0]  rv_q [NCH];
  logic [CW-1:0]  rv_d [NCH];
`endif

  // Prescaler: TICK is registered, so it is high in the cycle after the
  // prescaler reaches CLK_DIV-1.
  always_comb begin
    tick_d = (psc_q == DW'(CLK_DIV - 1));
    psc_d  = tick_d ? '0 : psc_q + 1'b1;
  end

  // Round-robin: first eligible index at or after ptr, then wrap to 0.
  always_comb begin
    elig    = bus.REQ & ~bus.CANCEL;
    win_vld = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!win_vld && elig[i] && (i >= 32'(ptr_q))) begin
        win_vld = 1'b1;
        win_idx = PW'(i);
      end
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!win_vld && elig[i]) begin
        win_vld = 1'b1;
        win_idx = PW'(i);
      end
    end
    ptr_d = ptr_q;
    if (win_vld) begin
      ptr_d = (win_idx == PW'(NCH - 1)) ? '0 : win_idx + 1'b1;
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      gnt_d[i] = win_vld && (win_idx == PW'(i));
    end
  end

  // Channel next state. Priority: CANCEL > load > tick, so a load on an
  // expiring edge restarts silently and a coincident tick is not counted.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      st_d[i]   = st_q[i];
      cnt_d[i]  = cnt_q[i];
      done_d[i] = 1'b0;
`ifdef TICK_SCHED_AUTORELOAD_EN
      per_d[i]  = per_q[i];
      rv_d[i]   = rv_q[i];
`endif
      if (bus.CANCEL[i]) begin
        st_d[i]  = CH_IDLE;
        cnt_d[i] = '0;
`ifdef TICK_SCHED_AUTORELOAD_EN
        per_d[i] = 1'b0;
`endif
      end else if (gnt_d[i]) begin
        if (bus.REQ_VAL[i*CW +: CW] == '0) begin
          // Zero delay: DONE lands in the same cycle as GNT.
          st_d[i]   = CH_IDLE;
          cnt_d[i]  = '0;
          done_d[i] = 1'b1;
`ifdef TICK_SCHED_AUTORELOAD_EN
          per_d[i]  = 1'b0;
`endif
        end else begin
          st_d[i]  = CH_RUN;
          cnt_d[i] = bus.REQ_VAL[i*CW +: CW];
`ifdef TICK_SCHED_AUTORELOAD_EN
          per_d[i] = bus.RELOAD[i];
          rv_d[i]  = bus.REQ_VAL[i*CW +: CW];
`endif
        end
      end else if ((st_q[i] == CH_RUN) && tick_q) begin
        if (cnt_q[i] == CW'(1)) begin
          done_d[i] = 1'b1;
`ifdef TICK_SCHED_AUTORELOAD_EN
          if (per_q[i]) begin
            cnt_d[i] = rv_q[i];
          end else begin
            st_d[i]  = CH_IDLE;
            cnt_d[i] = '0;
          end
`else
          st_d[i]  = CH_IDLE;
          cnt_d[i] = '0;
`endif
        end else begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      psc_q  <= '0;
      tick_q <= 1'b0;
      ptr_q  <= '0;
      gnt_q  <= '0;
      done_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        st_q[i]  <= CH_IDLE;
        cnt_q[i] <= '0;
`ifdef TICK_SCHED_AUTORELOAD_EN
        rv_q[i]  <= '0;
`endif
      end
`ifdef TICK_SCHED_AUTORELOAD_EN
      per_q <= '0;
`endif
    end else begin
      psc_q  <= psc_d;
      tick_q <= tick_d;
      ptr_q  <= ptr_d;
      gnt_q  <= gnt_d;
      done_q <= done_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
`ifdef TICK_SCHED_AUTORELOAD_EN
        rv_q[i]  <= rv_d[i];
`endif
      end
`ifdef TICK_SCHED_AUTORELOAD_EN
      per_q <= per_d;
`endif
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      busy[i] = (st_q[i] == CH_RUN);
    end
  end

  assign bus.GNT  = gnt_q;
  assign bus.BUSY = busy;
  assign bus.DONE = done_q;
  assign bus.TICK = tick_q;

endmodule
